uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle done pulse and holds it for the host.
- Presents bytes to the host through a first-word-fall-through valid/ready read port.
- Reports fill level and a sticky overrun flag, so the host can tolerate bursty reads without losing characters silently.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- wr_data  input  8  received byte; connects to the receiver's rx_data.
- wr_en  input  1  one-cycle write strobe; connects to the receiver's rx_done.
- rd_data  output  8  byte at the head of the FIFO; meaningful only while rd_valid=1.
- rd_valid  output  1  FIFO non-empty; head byte is available.
- rd_ready  input  1  host accepts the head byte.
- count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0; equals ~rd_valid.
- overrun  output  1  sticky: a write was dropped because the FIFO was full.
- ovr_clr  input  1  one-cycle clear of overrun.
- flush  input  1  discard all stored bytes.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - full=0, empty=1, rd_valid=0, overrun=0.
  - rd_data=8'h00 while empty.
  - Storage array is not cleared.
- Reset asserted mid-burst discards contents. The next wr_en after release is stored at entry 0.
- Storage: DEPTH x 8 register array.
  - Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate ADDR_W+1 register.
  - full, empty and rd_valid are decoded from the registered count.
- Push condition: push = wr_en & (~full | pop).
  - On push, mem[wr_ptr]<=wr_data and wr_ptr increments.
- Pop condition: pop = rd_valid & rd_ready.
  - On pop, rd_ptr increments.
  - rd_ready while empty is ignored and causes no pointer change.
- rd_data is a combinational read of mem[rd_ptr]. It is forced to 8'h00 when empty.
- Latency: a byte pushed at edge N gives rd_valid=1 and rd_data=that byte after edge N, with no further cycles.
  - A push into an empty FIFO cannot be popped in the same cycle.
- count update:
  - +1 on push without pop.
  - -1 on pop without push.
  - Unchanged on both or neither.
- Simultaneous push and pop when full: both take effect; count stays DEPTH and no overrun.
- Simultaneous push and pop when empty is impossible, because pop requires rd_valid. Only the push occurs.
- Overrun:
  - wr_en & full & ~pop drops wr_data; pointers and count are unchanged.
  - overrun<=1 at that edge.
  - ovr_clr=1 clears overrun at the edge.
  - If a drop and ovr_clr occur in the same cycle, set wins and overrun stays 1.
- Flush:
  - flush=1 sets wr_ptr=rd_ptr=0 and count=0 at the edge.
  - It overrides push and pop in the same cycle: the concurrent wr_en byte is discarded and no overrun is flagged.
  - Flush does not clear overrun.
- Priority per edge: reset > flush > push/pop.
- No combinational path from wr_en to any output. rd_valid depends only on registered state, so there is no path from rd_ready to rd_valid.

Test Plan:
- Reset then single byte: rst_n low 2 cycles, then wr_en with wr_data=8'hA5 for 1 cycle.
  - Next cycle: rd_valid=1, rd_data=8'hA5, count=1, empty=0.
  - Pulse rd_ready: count=0, rd_valid=0, rd_data=8'h00.
- Fill and overrun (DEPTH=16): write 8'h00..8'h0F, then write 8'h10 with rd_ready=0.
  - After the 16th write: full=1, count=16.
  - The 8'h10 write leaves count=16 and sets overrun=1.
  - Draining returns 8'h00..8'h0F in order; the 8'h10 is absent.
- Full with simultaneous read/write: fill to 16, then assert wr_en(8'h55) and rd_ready in the same cycle.
  - count stays 16, overrun stays 0, and the head becomes 8'h01.
  - The 16th read returns 8'h55.
- Pointer wrap: run 40 interleaved write/read pairs of incrementing data, keeping count between 0 and 3.
  - Every byte is read back in order; no data loss across the wraps at 15->0.
- Flush, clear and set-vs-clear: with count=5, assert flush together with wr_en(8'h77).
  - Next cycle: count=0, empty=1, overrun unchanged.
  - With overrun=1, ovr_clr alone gives overrun=0.
  - ovr_clr together with a dropped write keeps overrun=1.
- Mid-operation reset: with count=7 and overrun=1, assert rst_n=0 for 1 cycle.
  - Result: count=0, overrun=0, rd_valid=0.
  - A following write of 8'h3C reads back as 8'h3C.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer between the UART receiver and the host.
// Bytes are captured on the receiver's done strobe and offered to the host
// through a first-word-fall-through valid/ready port. The block also reports
// the fill level and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    input  logic              ovr_clr,
    input  logic              flush
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overrun_q;

    logic              is_full;
    logic              is_empty;
    logic              pop;
    logic              push;
    logic              drop;

    // Status decode from the registered count only, so neither wr_en nor
    // rd_ready reaches any status output combinationally.
    always_comb begin
        is_full  = (count_q == CNT_FULL);
        is_empty = (count_q == '0);
    end

    // Handshake decode. A full FIFO still accepts a byte when the head is
    // leaving in the same cycle; otherwise a write while full is dropped.
    always_comb begin
        pop  = ~is_empty & rd_ready;
        push = wr_en & (~is_full | pop);
        drop = wr_en & is_full & ~pop;
    end

    // Head byte is a plain read of the array, held at zero while empty so the
    // host never sees stale data from a previous fill.
    always_comb begin
        rd_data = is_empty ? 8'h00 : mem[rd_ptr];
    end

    // Storage write; the array itself is never reset or cleared.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and fill count; flush behaves like a reset of the queue state.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Sticky overrun: a drop sets it and wins over a same-cycle clear. A byte
    // arriving together with flush is discarded on purpose, not flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop && !flush) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    // Output wiring.
    always_comb begin
        count    = count_q;
        full     = is_full;
        empty    = is_empty;
        rd_valid = ~is_empty;
        overrun  = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              ovr_clr;
    logic              flush;

    int n_vec = 0;
    int n_err = 0;

    byte unsigned m_q[$];
    bit           m_ovr;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .flush    (flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour: a byte queue plus an overrun bit.
    task automatic model_edge(input bit rst, input bit we, input byte unsigned d,
                              input bit rr, input bit fl, input bit oc);
        bit popped;
        bit accepted;
        if (!rst) begin
            m_q.delete();
            m_ovr = 1'b0;
        end else if (fl) begin
            m_q.delete();
            if (oc) m_ovr = 1'b0;
        end else begin
            popped   = (m_q.size() > 0) && rr;
            accepted = we && ((m_q.size() < DEPTH) || popped);
            if (popped) void'(m_q.pop_front());
            if (accepted) m_q.push_back(d);
            if (we && !accepted) m_ovr = 1'b1;
            else if (oc) m_ovr = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("count",    32'(count),    32'(m_q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
        chk("rd_data",  32'(rd_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("overrun",  32'(overrun),  32'(m_ovr));
    endtask

    task automatic step(input bit rst, input bit we, input byte unsigned d,
                        input bit rr, input bit fl, input bit oc);
        rst_n    = rst;
        wr_en    = we;
        wr_data  = d;
        rd_ready = rr;
        flush    = fl;
        ovr_clr  = oc;
        @(posedge clk);
        model_edge(rst, we, d, rr, fl, oc);
        #1;
        check_all();
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        ovr_clr  = 1'b0;
        wr_data  = 8'h00;
    endtask

    task automatic wr(input byte unsigned d);
        step(1, 1, d, 0, 0, 0);
    endtask

    task automatic rd();
        step(1, 0, 8'h00, 1, 0, 0);
    endtask

    initial begin
        int wp, rp, cyc;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        rd_ready = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
        m_ovr = 1'b0;

        // Reset, then a single byte through
        step(0, 0, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        wr(8'hA5);
        chk("single_data",  32'(rd_data),  32'hA5);
        chk("single_valid", 32'(rd_valid), 32'h1);
        rd();
        chk("single_drain", 32'(rd_data),  32'h00);

        // Fill and overrun
        for (int i = 0; i < DEPTH; i++) wr(byte'(i));
        chk("fill_full",  32'(full),  32'h1);
        chk("fill_count", 32'(count), 32'd16);
        wr(8'h10);
        chk("drop_count", 32'(count),   32'd16);
        chk("drop_ovr",   32'(overrun), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            rd();
        end
        chk("drain_empty", 32'(empty), 32'h1);
        step(1, 0, 8'h00, 0, 0, 1);
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) wr(byte'(i));
        step(1, 1, 8'h55, 1, 0, 0);
        chk("rw_full_count", 32'(count),   32'd16);
        chk("rw_full_ovr",   32'(overrun), 32'h0);
        chk("rw_full_head",  32'(rd_data), 32'h01);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("rw_full_last", 32'(rd_data), 32'h55);
            rd();
        end

        // Pointer wrap with interleaved traffic
        wr(8'h00);
        for (int k = 1; k < 40; k++) begin
            chk("wrap_head", 32'(rd_data), 32'(k - 1));
            step(1, 1, byte'(k), 1, 0, 0);
        end
        chk("wrap_last", 32'(rd_data), 32'd39);
        rd();

        // Flush with concurrent write, then overrun clear and set-vs-clear
        for (int i = 0; i < 5; i++) wr(byte'(8'h20 + i));
        step(1, 1, 8'h77, 0, 1, 0);
        chk("flush_count", 32'(count),   32'h0);
        chk("flush_empty", 32'(empty),   32'h1);
        chk("flush_ovr",   32'(overrun), 32'h0);
        for (int i = 0; i < DEPTH; i++) wr(byte'(8'h40 + i));
        wr(8'hEE);
        chk("ovr_set", 32'(overrun), 32'h1);
        step(1, 0, 8'h00, 0, 1, 0);
        chk("flush_keeps_ovr", 32'(overrun), 32'h1);
        step(1, 0, 8'h00, 0, 0, 1);
        chk("ovr_clr_alone", 32'(overrun), 32'h0);
        for (int i = 0; i < DEPTH; i++) wr(byte'(8'h60 + i));
        step(1, 1, 8'hEF, 0, 0, 1);
        chk("set_beats_clr", 32'(overrun), 32'h1);

        // Mid-operation reset
        for (int i = 0; i < 9; i++) rd();
        chk("pre_rst_count", 32'(count), 32'd7);
        step(0, 1, 8'h99, 1, 0, 0);
        chk("mid_rst_count", 32'(count),    32'h0);
        chk("mid_rst_ovr",   32'(overrun),  32'h0);
        chk("mid_rst_valid", 32'(rd_valid), 32'h0);
        wr(8'h3C);
        chk("post_rst_data", 32'(rd_data), 32'h3C);
        rd();

        // Randomized traffic in phases of varying write/read pressure
        for (int ph = 0; ph < 20; ph++) begin
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (cyc = 0; cyc < 150; cyc++) begin
                step(!($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 99) < wp),
                     byte'($urandom),
                     ($urandom_range(0, 99) < rp),
                     ($urandom_range(0, 79) == 0),
                     ($urandom_range(0, 15) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
